// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//
// Purpose: sequences every access to a 32x16 register file that has a single
// mode select (rf_RW: 0 = read both operands, 1 = write) and registered read
// outputs. It arbitrates between the operand-read requester (decode) and the
// write-back requester. Write-backs are queued in a small in-order FIFO, and a
// read is held off while a queued write targets one of its operands.
//
// Optional feature: define RFC_BYPASS_EN to let a read proceed past queued
// writes to its operands. The youngest matching queued data is captured at
// grant time and returned in place of the register-file output.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_req, rd_ra, rd_rb     read request and operand register numbers
//   rd_gnt                   read issued to the register file this cycle (comb)
//   rd_valid, rd_da, rd_db   read result, one cycle after rd_gnt
//   wr_valid, wr_reg, wr_data, wr_ready   write-back handshake (push on valid&&ready)
//   wbuf_count               write-back FIFO occupancy
//   rf_regA, rf_regB, rf_regC, rf_dado, rf_RW   register-file control
//   rf_saidaA, rf_saidaB     register-file registered read data
module regfile_access_ctrl #(
  parameter int WBUF_DEPTH = 4,
  parameter int AW         = 5,
  parameter int DW         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_req,
  input  logic [AW-1:0]               rd_ra,
  input  logic [AW-1:0]               rd_rb,
  output logic                        rd_gnt,
  output logic                        rd_valid,
  output logic [DW-1:0]               rd_da,
  output logic [DW-1:0]               rd_db,
  input  logic                        wr_valid,
  input  logic [AW-1:0]               wr_reg,
  input  logic [DW-1:0]               wr_data,
  output logic                        wr_ready,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
  output logic [AW-1:0]               rf_regA,
  output logic [AW-1:0]               rf_regB,
  output logic [AW-1:0]               rf_regC,
  output logic [DW-1:0]               rf_dado,
  output logic                        rf_RW,
  input  logic [DW-1:0]               rf_saidaA,
  input  logic [DW-1:0]               rf_saidaB
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  // Write-back FIFO storage; small enough to live in flops, and every entry is
  // compared against the read operands each cycle.
  logic [AW-1:0] wreg_mem  [WBUF_DEPTH];
  logic [DW-1:0] wdata_mem [WBUF_DEPTH];

  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  grant_e        last_grant_reg;
  logic          rd_valid_reg;
  logic [AW-1:0] rega_reg;
  logic [AW-1:0] regb_reg;
  logic [AW-1:0] regc_reg;
  logic [DW-1:0] dado_reg;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic hazard;
  logic read_blocked;
  logic grant_read;
  logic grant_write;
  logic [WBUF_DEPTH-1:0] entry_match;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(WBUF_DEPTH));

  // An entry is live when its distance from the head is below the occupancy.
  // Only contents before this cycle's push are considered, so a write pushed
  // alongside a granted read is younger and never blocks it.
  genvar gi;
  generate
    for (gi = 0; gi < WBUF_DEPTH; gi++) begin : g_hazard
      logic [PW-1:0] offset;
      assign offset = PW'(gi) - rd_ptr_reg;
      assign entry_match[gi] = ({1'b0, offset} < count_reg) &&
                               ((wreg_mem[gi] == rd_ra) || (wreg_mem[gi] == rd_rb));
    end
  endgenerate

  assign hazard = rd_req && (|entry_match);

`ifdef RFC_BYPASS_EN
  assign read_blocked = 1'b0;
`else
  assign read_blocked = hazard;
`endif

  // Read wins when nothing is queued; under contention it alternates with
  // writes, and a hazard makes writes drain until it clears. No access is
  // issued while reset is held so a flushed write never reaches the file.
  assign grant_read  = !rst && rd_req &&
                       (fifo_empty || (!read_blocked && (last_grant_reg == GRANT_WRITE)));
  assign grant_write = !rst && !grant_read && !fifo_empty;

  assign push = wr_valid && !fifo_full;
  assign pop  = grant_write;

  assign wr_ready   = !fifo_full;
  assign wbuf_count = count_reg;
  assign rd_gnt     = grant_read;
  assign rd_valid   = rd_valid_reg;

  assign rf_RW   = grant_write;
  assign rf_regA = grant_read  ? rd_ra                  : rega_reg;
  assign rf_regB = grant_read  ? rd_rb                  : regb_reg;
  assign rf_regC = grant_write ? wreg_mem[rd_ptr_reg]   : regc_reg;
  assign rf_dado = grant_write ? wdata_mem[rd_ptr_reg]  : dado_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      wreg_mem[wr_ptr_reg]  <= wr_reg;
      wdata_mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      last_grant_reg <= GRANT_WRITE;
      rd_valid_reg   <= 1'b0;
      rega_reg       <= '0;
      regb_reg       <= '0;
      regc_reg       <= '0;
      dado_reg       <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (grant_read) begin
        last_grant_reg <= GRANT_READ;
        rega_reg       <= rd_ra;
        regb_reg       <= rd_rb;
      end else if (grant_write) begin
        last_grant_reg <= GRANT_WRITE;
        regc_reg       <= wreg_mem[rd_ptr_reg];
        dado_reg       <= wdata_mem[rd_ptr_reg];
      end
      rd_valid_reg <= grant_read;
    end
  end

`ifdef RFC_BYPASS_EN
  logic          byp_hit_a_next;
  logic          byp_hit_b_next;
  logic [DW-1:0] byp_data_a_next;
  logic [DW-1:0] byp_data_b_next;
  logic          byp_hit_a_reg;
  logic          byp_hit_b_reg;
  logic [DW-1:0] byp_data_a_reg;
  logic [DW-1:0] byp_data_b_reg;

  // Walk from head (oldest) to tail so the last match seen is the youngest.
  always_comb begin
    byp_hit_a_next  = 1'b0;
    byp_hit_b_next  = 1'b0;
    byp_data_a_next = '0;
    byp_data_b_next = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if (CW'(k) < count_reg) begin
        if (wreg_mem[rd_ptr_reg + PW'(k)] == rd_ra) begin
          byp_hit_a_next  = 1'b1;
          byp_data_a_next = wdata_mem[rd_ptr_reg + PW'(k)];
        end
        if (wreg_mem[rd_ptr_reg + PW'(k)] == rd_rb) begin
          byp_hit_b_next  = 1'b1;
          byp_data_b_next = wdata_mem[rd_ptr_reg + PW'(k)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_a_reg  <= 1'b0;
      byp_hit_b_reg  <= 1'b0;
      byp_data_a_reg <= '0;
      byp_data_b_reg <= '0;
    end else if (grant_read) begin
      byp_hit_a_reg  <= byp_hit_a_next;
      byp_hit_b_reg  <= byp_hit_b_next;
      byp_data_a_reg <= byp_data_a_next;
      byp_data_b_reg <= byp_data_b_next;
    end
  end

  assign rd_da = byp_hit_a_reg ? byp_data_a_reg : rf_saidaA;
  assign rd_db = byp_hit_b_reg ? byp_data_b_reg : rf_saidaB;
`else
  assign rd_da = rf_saidaA;
  assign rd_db = rf_saidaB;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl: drives directed stimulus against a
// behavioural 32x16 register file with registered reads and compares the
// controller outputs to hand-computed expectations.
module tb_regfile_access_ctrl;

  localparam int AW = 5;
  localparam int DW = 16;
`ifdef RFC_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_ra, rd_rb;
  logic          rd_gnt, rd_valid;
  logic [DW-1:0] rd_da, rd_db;
  logic          wr_valid;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [2:0]    wbuf_count;
  logic [AW-1:0] rf_regA, rf_regB, rf_regC;
  logic [DW-1:0] rf_dado;
  logic          rf_RW;
  logic [DW-1:0] rf_saidaA = '0;
  logic [DW-1:0] rf_saidaB = '0;

  logic [DW-1:0] rf_mem [32] = '{default: 16'h0000};

  int passed = 0;
  int total  = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.WBUF_DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_ra(rd_ra), .rd_rb(rd_rb),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_da(rd_da), .rd_db(rd_db),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_ready(wr_ready), .wbuf_count(wbuf_count),
    .rf_regA(rf_regA), .rf_regB(rf_regB), .rf_regC(rf_regC),
    .rf_dado(rf_dado), .rf_RW(rf_RW),
    .rf_saidaA(rf_saidaA), .rf_saidaB(rf_saidaB)
  );

  // Register file: one mode select, registered read outputs.
  always @(posedge clk) begin
    if (rf_RW) rf_mem[rf_regC] <= rf_dado;
    else begin
      rf_saidaA <= rf_mem[rf_regA];
      rf_saidaB <= rf_mem[rf_regB];
    end
  end

  typedef struct {
    bit        rq;
    bit [4:0]  ra, rb;
    bit        wv;
    bit [4:0]  wreg;
    bit [15:0] wdata;
    bit        e_gnt, e_rw, e_rdy;
    int        e_cnt;
    bit        e_rv;
    bit [15:0] e_da, e_db;
    bit [4:0]  e_regc;
    bit [15:0] e_dado;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
  endtask

  // One clock: drive after the edge, sample on the falling edge.
  task automatic cyc(input bit rq, input bit [4:0] ra, input bit [4:0] rb,
                     input bit wv, input bit [4:0] wreg, input bit [15:0] wdata);
    @(posedge clk);
    #1;
    rd_req = rq; rd_ra = ra; rd_rb = rb;
    wr_valid = wv; wr_reg = wreg; wr_data = wdata;
    @(negedge clk);
    cycle++;
    $display("cyc %0d rq=%0b ra=%0d rb=%0d wv=%0b wreg=%0d | gnt=%0b rw=%0b regC=%0d dado=%h rdy=%0b cnt=%0d rv=%0b da=%h db=%h",
             cycle, rq, ra, rb, wv, wreg, rd_gnt, rf_RW, rf_regC, rf_dado,
             wr_ready, wbuf_count, rd_valid, rd_da, rd_db);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Hold a read until granted (bounded), then check the result one cycle later.
  task automatic read_op(input bit [4:0] ra, input bit [4:0] rb,
                         input bit [15:0] ea, input bit [15:0] eb,
                         input int ewait, input string nm);
    int n;
    n = 0;
    cyc(1, ra, rb, 0, 0, 0);
    while (!rd_gnt && n < 20) begin
      n++;
      cyc(1, ra, rb, 0, 0, 0);
    end
    chk({nm, "_wait"}, n, ewait);
    cyc(0, 0, 0, 0, 0, 0);
    chk({nm, "_rv"}, int'(rd_valid), 1);
    chk({nm, "_da"}, int'(rd_da), int'(ea));
    chk({nm, "_db"}, int'(rd_db), int'(eb));
  endtask

  initial begin
    //          rq ra rb  wv wr  wdata     gnt rw rdy cnt rv da       db       regc dado
    vecs[0]  = '{0, 0, 0, 1, 3, 16'h1234, 0, 0, 1, 0, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[1]  = '{0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 1, 0, 16'h0,    16'h0,    3, 16'h1234};
    vecs[2]  = '{0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[3]  = '{1, 3, 0, 0, 0, 16'h0,    1, 0, 1, 0, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[4]  = '{0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 16'h1234, 16'h0000, 0, 16'h0};
    vecs[5]  = '{1, 5, 6, 1, 1, 16'h1111, 1, 0, 1, 0, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[6]  = '{1, 5, 6, 1, 2, 16'h2222, 0, 1, 1, 1, 1, 16'h0,    16'h0,    1, 16'h1111};
    vecs[7]  = '{1, 5, 6, 1, 1, 16'h3333, 1, 0, 1, 1, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[8]  = '{1, 5, 6, 1, 2, 16'h4444, 0, 1, 1, 2, 1, 16'h0,    16'h0,    2, 16'h2222};
    vecs[9]  = '{1, 5, 6, 1, 1, 16'h5555, 1, 0, 1, 2, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[10] = '{1, 5, 6, 1, 2, 16'h6666, 0, 1, 1, 3, 1, 16'h0,    16'h0,    1, 16'h3333};
    vecs[11] = '{1, 5, 6, 1, 1, 16'h7777, 1, 0, 1, 3, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[12] = '{1, 5, 6, 1, 2, 16'h8888, 0, 1, 0, 4, 1, 16'h0,    16'h0,    2, 16'h4444};
    vecs[13] = '{0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 3, 0, 16'h0,    16'h0,    1, 16'h5555};
    vecs[14] = '{0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 2, 0, 16'h0,    16'h0,    2, 16'h6666};
    vecs[15] = '{0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 1, 0, 16'h0,    16'h0,    1, 16'h7777};
    vecs[16] = '{0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[17] = '{1, 1, 2, 0, 0, 16'h0,    1, 0, 1, 0, 0, 16'h0,    16'h0,    0, 16'h0};
    vecs[18] = '{0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 16'h7777, 16'h6666, 0, 16'h0};

    rst = 1'b1; rd_req = 0; rd_ra = 0; rd_rb = 0; wr_valid = 0; wr_reg = 0; wr_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cnt", int'(wbuf_count), 0);
    chk("reset_rdy", int'(wr_ready), 1);
    chk("reset_rv",  int'(rd_valid), 0);
    chk("reset_rw",  int'(rf_RW), 0);

    // Basic write/read, alternation under contention, fill to full, drain order.
    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].rq, vecs[i].ra, vecs[i].rb, vecs[i].wv, vecs[i].wreg, vecs[i].wdata);
      chk($sformatf("v%0d_gnt", i), int'(rd_gnt), int'(vecs[i].e_gnt));
      chk($sformatf("v%0d_rw", i),  int'(rf_RW),  int'(vecs[i].e_rw));
      chk($sformatf("v%0d_rdy", i), int'(wr_ready), int'(vecs[i].e_rdy));
      chk($sformatf("v%0d_cnt", i), int'(wbuf_count), vecs[i].e_cnt);
      chk($sformatf("v%0d_rv", i),  int'(rd_valid), int'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_da", i), int'(rd_da), int'(vecs[i].e_da));
        chk($sformatf("v%0d_db", i), int'(rd_db), int'(vecs[i].e_db));
      end
      if (vecs[i].e_rw) begin
        chk($sformatf("v%0d_regc", i), int'(rf_regC), int'(vecs[i].e_regc));
        chk($sformatf("v%0d_dado", i), int'(rf_dado), int'(vecs[i].e_dado));
      end
    end

    // Hazard on a freshly buffered r7 (last grant is WRITE when the read arrives).
    cyc(0, 0, 0, 1, 8, 16'h0808);
    cyc(0, 0, 0, 1, 7, 16'hBEEF);
    chk("haz_pop_r8", int'(rf_regC), 8);
    read_op(7, 0, 16'hBEEF, 16'h0000, (BYP != 0) ? 0 : 1, "haz_r7");
    idle(3);
    chk("haz_drained", int'(wbuf_count), 0);

    // Two queued writes to r9; the read must see the younger value.
    cyc(1, 20, 21, 1, 4, 16'h0404);
    chk("r9_b0_gnt", int'(rd_gnt), 1);
    cyc(1, 20, 21, 1, 4, 16'h0405);
    chk("r9_b1_rw", int'(rf_RW), 1);
    cyc(1, 20, 21, 1, 9, 16'h0001);
    chk("r9_b2_gnt", int'(rd_gnt), 1);
    cyc(1, 20, 21, 1, 9, 16'h0002);
    chk("r9_b3_rw", int'(rf_RW), 1);
    chk("r9_b3_cnt", int'(wbuf_count), 2);
    read_op(9, 9, 16'h0002, 16'h0002, (BYP != 0) ? 0 : 2, "r9_dup");
    idle(4);
    chk("r9_drained", int'(wbuf_count), 0);

    // Reset with three buffered writes and a pending read.
    cyc(1, 20, 21, 1, 11, 16'h0B11);
    cyc(1, 20, 21, 1, 12, 16'h0C12);
    cyc(1, 20, 21, 1, 13, 16'h0D13);
    cyc(1, 20, 21, 1, 14, 16'h0E14);
    cyc(1, 20, 21, 1, 15, 16'h0F15);
    chk("pre_rst_gnt", int'(rd_gnt), 1);
    @(posedge clk);
    #1 rst = 1'b1; wr_valid = 0;
    @(posedge clk);
    #1 rst = 1'b0; rd_req = 0;
    @(negedge clk);
    chk("post_rst_cnt", int'(wbuf_count), 0);
    chk("post_rst_rdy", int'(wr_ready), 1);
    chk("post_rst_rv",  int'(rd_valid), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk($sformatf("post_rst_rw%0d", i), int'(rf_RW), 0);
    end
    read_op(13, 14, 16'h0000, 16'h0000, 0, "flushed_13_14");
    read_op(15, 12, 16'h0000, 16'h0C12, 0, "flushed_15_kept_12");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
